// File: rtl/udma_spim_cfg_seq_pkg.sv
// udma_spim_cfg_seq_pkg: channel, register index, CFG bit and FSM state definitions for the SPIM cfg sequencer
package udma_spim_cfg_seq_pkg;

    typedef enum logic [1:0] {
        CH_RX   = 2'd0,
        CH_TX   = 2'd1,
        CH_CMD  = 2'd2,
        CH_RSVD = 2'd3
    } chan_e;

    localparam logic [4:0] REG_RX_BASE   = 5'h00;
    localparam logic [4:0] REG_TX_BASE   = 5'h04;
    localparam logic [4:0] REG_CMD_BASE  = 5'h08;
    localparam logic [4:0] REG_SADDR_OFS = 5'd0;
    localparam logic [4:0] REG_SIZE_OFS  = 5'd1;
    localparam logic [4:0] REG_CFG_OFS   = 5'd2;

    localparam int CFG_CONT   = 0;
    localparam int CFG_DS_LSB = 1;
    localparam int CFG_EN     = 4;
    localparam int CFG_PEND   = 5;
    localparam int CFG_CLR    = 6;
    localparam int CFG_BP     = 7;

    localparam logic [1:0]  DS_CMD        = 2'b10;
    localparam logic [31:0] CFG_BUSY_MASK = (32'd1 << CFG_EN) | (32'd1 << CFG_PEND);
    localparam logic [31:0] CFG_CLR_WORD  = 32'd1 << CFG_CLR;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SADDR,
        S_WR_SIZE,
        S_WR_CFG,
        S_GAP,
        S_POLL,
        S_CLR,
        S_DONE,
        S_ABORTED
    } state_e;

    function automatic logic [4:0] reg_base(input chan_e ch);
        return (ch == CH_TX) ? REG_TX_BASE : (ch == CH_CMD) ? REG_CMD_BASE : REG_RX_BASE;
    endfunction

endpackage

// File: rtl/udma_spim_cfg_seq_req.sv
// udma_spim_cfg_req: holds one cfg request stable until accepted and returns an accept strobe with read data
module udma_spim_cfg_req (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic        rwn_i,
    output logic [31:0] cfg_data_o,
    output logic [4:0]  cfg_addr_o,
    output logic        cfg_valid_o,
    output logic        cfg_rwn_o,
    input  logic [31:0] cfg_data_i,
    input  logic        cfg_ready_i,
    output logic        ack_o,
    output logic [31:0] rdata_o
);

    logic        valid_q, valid_d;
    logic        rwn_q, rwn_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = start_i | (valid_q & ~cfg_ready_i);
        addr_d  = start_i ? addr_i : addr_q;
        data_d  = start_i ? data_i : data_q;
        rwn_d   = start_i ? rwn_i : rwn_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rwn_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rwn_q   <= rwn_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign cfg_valid_o = valid_q;
    assign cfg_addr_o  = addr_q;
    assign cfg_data_o  = data_q;
    assign cfg_rwn_o   = rwn_q;
    assign ack_o       = valid_q & cfg_ready_i;
    assign rdata_o     = cfg_data_i;

endmodule

// File: rtl/udma_spim_cfg_seq.sv
// udma_spim_cfg_seq: programs one uDMA SPIM channel from a descriptor and polls it idle
// UDMA_SPIM_CFG_SEQ_TIMEOUT_EN bounds polling to POLL_TIMEOUT reads before clearing the channel
module udma_spim_cfg_seq
    import udma_spim_cfg_seq_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned POLL_TIMEOUT   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      desc_valid_i,
    output logic                      desc_ready_o,
    input  logic [1:0]                desc_chan_i,
    input  logic [L2_AWIDTH_NOAL-1:0] desc_saddr_i,
    input  logic [TRANS_SIZE-1:0]     desc_size_i,
    input  logic [1:0]                desc_datasize_i,
    input  logic                      desc_cont_i,
    input  logic                      desc_bp_i,
    input  logic                      abort_i,
    output logic [31:0]               cfg_data_o,
    output logic [4:0]                cfg_addr_o,
    output logic                      cfg_valid_o,
    output logic                      cfg_rwn_o,
    input  logic [31:0]               cfg_data_i,
    input  logic                      cfg_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    if (POLL_GAP < 1 || POLL_GAP > 255 || POLL_TIMEOUT < 1) begin : g_param_chk
        $error("udma_spim_cfg_seq: POLL_GAP must be 1..255 and POLL_TIMEOUT at least 1");
    end

    state_e                    state_q, state_d;
    chan_e                     chan_q, chan_d;
    logic [L2_AWIDTH_NOAL-1:0] saddr_q, saddr_d;
    logic [TRANS_SIZE-1:0]     size_q, size_d;
    logic [1:0]                ds_q, ds_d;
    logic                      cont_q, cont_d;
    logic                      bp_q, bp_d;
    logic [7:0]                gap_q, gap_d;
    logic                      abort_q, abort_d;
    logic                      rej_q, rej_d;
    logic                      accept, abort_hit, poll_idle, timeout;
    logic                      req_start, req_rwn, req_ack;
    logic [4:0]                req_addr;
    logic [31:0]               req_data, req_rdata, cfg_word;

`ifdef UDMA_SPIM_CFG_SEQ_TIMEOUT_EN
    localparam int unsigned PCW = $clog2(POLL_TIMEOUT + 1);
    logic [PCW-1:0] polls_q, polls_d;
    always_comb begin
        polls_d = accept ? '0 : (state_q == S_POLL && req_ack) ? polls_q + 1'b1 : polls_q;
        timeout = polls_q == PCW'(POLL_TIMEOUT - 1);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) polls_q <= '0;
        else polls_q <= polls_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        accept    = (state_q == S_IDLE) & desc_valid_i;
        chan_d    = accept ? chan_e'(desc_chan_i) : chan_q;
        saddr_d   = accept ? desc_saddr_i : saddr_q;
        size_d    = accept ? desc_size_i : size_q;
        ds_d      = accept ? desc_datasize_i : ds_q;
        cont_d    = accept ? desc_cont_i : cont_q;
        bp_d      = accept ? desc_bp_i : bp_q;
        rej_d     = accept & (chan_e'(desc_chan_i) == CH_RSVD);
        abort_hit = abort_q | abort_i;
        poll_idle = ~|(req_rdata & CFG_BUSY_MASK);
        state_d   = state_q;
        case (state_q)
            S_IDLE:     state_d = (accept && !rej_d) ? S_WR_SADDR : S_IDLE;
            S_WR_SADDR: if (req_ack) state_d = abort_hit ? S_CLR : S_WR_SIZE;
            S_WR_SIZE:  if (req_ack) state_d = abort_hit ? S_CLR : S_WR_CFG;
            S_WR_CFG:   if (req_ack) state_d = abort_hit ? S_CLR : cont_q ? S_DONE : S_GAP;
            S_GAP:      state_d = abort_hit ? S_CLR : (gap_q == 8'd0) ? S_POLL : S_GAP;
            // an idle poll result takes priority over a simultaneous abort
            S_POLL:     if (req_ack) state_d = poll_idle ? S_DONE : (abort_hit | timeout) ? S_CLR : S_GAP;
            S_CLR:      if (req_ack) state_d = S_ABORTED;
            default:    state_d = S_IDLE;
        endcase
        gap_d   = (state_d != S_GAP) ? gap_q : (state_q != S_GAP) ? 8'(POLL_GAP - 1) : gap_q - 8'd1;
        abort_d = abort_hit & (state_d == state_q) &
                  (state_q inside {S_WR_SADDR, S_WR_SIZE, S_WR_CFG, S_GAP, S_POLL});
        cfg_word                         = 32'h0;
        cfg_word[CFG_CONT]               = cont_d;
        cfg_word[CFG_DS_LSB +: 2]        = (chan_d == CH_CMD) ? DS_CMD : ds_d;
        cfg_word[CFG_EN]                 = 1'b1;
        cfg_word[CFG_BP]                 = bp_d & (chan_d == CH_RX);
        req_start = (state_d != state_q) & (state_d inside {S_WR_SADDR, S_WR_SIZE, S_WR_CFG, S_POLL, S_CLR});
        req_rwn   = state_d == S_POLL;
        req_addr  = reg_base(chan_d) + ((state_d == S_WR_SADDR) ? REG_SADDR_OFS :
                                        (state_d == S_WR_SIZE) ? REG_SIZE_OFS : REG_CFG_OFS);
        req_data  = (state_d == S_WR_SADDR) ? 32'(saddr_d) :
                    (state_d == S_WR_SIZE) ? 32'(size_d) :
                    (state_d == S_WR_CFG) ? cfg_word :
                    (state_d == S_CLR) ? CFG_CLR_WORD : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            chan_q  <= CH_RX;
            saddr_q <= '0;
            size_q  <= '0;
            ds_q    <= '0;
            cont_q  <= 1'b0;
            bp_q    <= 1'b0;
            gap_q   <= '0;
            abort_q <= 1'b0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            saddr_q <= saddr_d;
            size_q  <= size_d;
            ds_q    <= ds_d;
            cont_q  <= cont_d;
            bp_q    <= bp_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
            rej_q   <= rej_d;
        end
    end

    udma_spim_cfg_req u_req (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (req_start),
        .addr_i      (req_addr),
        .data_i      (req_data),
        .rwn_i       (req_rwn),
        .cfg_data_o  (cfg_data_o),
        .cfg_addr_o  (cfg_addr_o),
        .cfg_valid_o (cfg_valid_o),
        .cfg_rwn_o   (cfg_rwn_o),
        .cfg_data_i  (cfg_data_i),
        .cfg_ready_i (cfg_ready_i),
        .ack_o       (req_ack),
        .rdata_o     (req_rdata)
    );

    assign desc_ready_o = state_q == S_IDLE;
    assign busy_o       = !(state_q inside {S_IDLE, S_DONE, S_ABORTED});
    assign done_o       = state_q == S_DONE;
    assign err_o        = (state_q == S_ABORTED) | rej_q;

endmodule
